// File: rtl/id_ex_alu_ctrl_stage.sv
// ID/EX stage: decodes one RV32I instruction per handshake into ALU control and operands,
// held in a valid/ready pipeline register with stall and flush.
package id_ex_alu_pkg;
    typedef enum logic [3:0] {
        nop_, add_, sub_, sl_, sr_, lt_, ge_, eq_, ne_, xor_, or_, and_, imm_
    } alu_op_e;

    typedef struct packed {
        alu_op_e op;
        logic    is_signed;
    } alu_sig_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
endpackage

module id_ex_alu_ctrl_stage
    import id_ex_alu_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter bit ILLEGAL_AS_NOP = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output alu_sig_t        alu_ctrl,
    output logic [XLEN-1:0] alu_in1,
    output logic [XLEN-1:0] alu_in2,
    output logic [XLEN-1:0] store_data,
    output logic [4:0]      rd,
    output logic            wb_en,
    output logic            is_branch,
    output logic            is_jump,
    output logic [XLEN-1:0] br_target,
    output logic            mem_re,
    output logic            mem_we,
    output logic            illegal
);
    typedef struct packed {
        alu_sig_t        ctrl;
        logic [XLEN-1:0] in1;
        logic [XLEN-1:0] in2;
        logic [XLEN-1:0] store_data;
        logic [4:0]      rd;
        logic            wb_en;
        logic            is_branch;
        logic            is_jump;
        logic [XLEN-1:0] br_target;
        logic            mem_re;
        logic            mem_we;
        logic            illegal;
    } dec_t;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u, imm_j;

    assign opcode = instr[6:0];
    assign f3     = instr[14:12];
    assign f7     = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_s  = XLEN'($signed({instr[31:25], instr[11:7]}));
    assign imm_b  = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'b0}));
    assign imm_j  = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));

    // Shared OP / OP-IMM f3 map; alt is f7[5], meaning SUB at f3=000 and arithmetic shift at 101.
    function automatic alu_sig_t arith_sig(input logic [2:0] fn3, input logic alt);
        alu_sig_t s;
        s = '{op: nop_, is_signed: 1'b0};
        case (fn3)
            3'b000:  s.op = alt ? sub_ : add_;
            3'b001:  s.op = sl_;
            3'b010:  s = '{op: lt_, is_signed: 1'b1};
            3'b011:  s.op = lt_;
            3'b100:  s.op = xor_;
            3'b101:  s = '{op: sr_, is_signed: alt};
            3'b110:  s.op = or_;
            default: s.op = and_;
        endcase
        return s;
    endfunction

    dec_t d;
    dec_t q;
    logic legal;
    logic writes;
    logic is_shift_imm;

    assign is_shift_imm = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path infers a latch.
        d              = '0;
        d.store_data   = rs2_data;
        legal          = 1'b1;
        writes         = 1'b0;
        case (opcode)
            OPC_OP: begin
                legal  = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
                d.ctrl = arith_sig(f3, f7[5]);
                d.in1  = rs1_data;
                d.in2  = rs2_data;
                writes = 1'b1;
            end
            OPC_OP_IMM: begin
                legal  = !is_shift_imm || (f7 == 7'h00) || ((f3 == 3'b101) && (f7 == 7'h20));
                d.ctrl = arith_sig(f3, (f3 == 3'b101) && f7[5]);
                d.in1  = rs1_data;
                d.in2  = is_shift_imm ? XLEN'(instr[24:20]) : imm_i;
                writes = 1'b1;
            end
            OPC_LUI: begin
                d.ctrl.op = imm_;
                d.in2     = imm_u;
                writes    = 1'b1;
            end
            OPC_AUIPC: begin
                d.ctrl.op = add_;
                d.in1     = pc;
                d.in2     = imm_u;
                writes    = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                // Link value pc+4; a JALR target depends on rs1 and is formed in EX.
                legal       = (opcode == OPC_JAL) || (f3 == 3'b000);
                d.ctrl.op   = add_;
                d.in1       = pc;
                d.in2       = XLEN'(4);
                d.is_jump   = 1'b1;
                d.br_target = (opcode == OPC_JAL) ? pc + imm_j : '0;
                writes      = 1'b1;
            end
            OPC_BRANCH: begin
                case (f3)
                    3'b000:  d.ctrl = '{op: eq_, is_signed: 1'b0};
                    3'b001:  d.ctrl = '{op: ne_, is_signed: 1'b0};
                    3'b100:  d.ctrl = '{op: lt_, is_signed: 1'b1};
                    3'b101:  d.ctrl = '{op: ge_, is_signed: 1'b1};
                    3'b110:  d.ctrl = '{op: lt_, is_signed: 1'b0};
                    3'b111:  d.ctrl = '{op: ge_, is_signed: 1'b0};
                    default: legal  = 1'b0;
                endcase
                d.in1       = rs1_data;
                d.in2       = rs2_data;
                d.is_branch = 1'b1;
                d.br_target = pc + imm_b;
            end
            OPC_LOAD: begin
                legal     = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
                d.ctrl.op = add_;
                d.in1     = rs1_data;
                d.in2     = imm_i;
                d.mem_re  = 1'b1;
                writes    = 1'b1;
            end
            OPC_STORE: begin
                legal     = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
                d.ctrl.op = add_;
                d.in1     = rs1_data;
                d.in2     = imm_s;
                d.mem_we  = 1'b1;
            end
            default: legal = 1'b0;
        endcase

        d.rd    = writes ? instr[11:7] : 5'd0;
        d.wb_en = writes && (instr[11:7] != 5'd0);

        if (!legal) begin
            d            = '0;
            d.store_data = rs2_data;
            d.illegal    = 1'b1;
        end
    end

    logic accept;
    logic emit;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign emit     = ILLEGAL_AS_NOP || !d.illegal;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            q         <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
            if (flush)          out_valid <= 1'b0;
            else if (accept)    out_valid <= emit;
            else if (out_ready) out_valid <= 1'b0;

            if (accept) q <= d;
        end
    end

    assign alu_ctrl   = q.ctrl;
    assign alu_in1    = q.in1;
    assign alu_in2    = q.in2;
    assign store_data = q.store_data;
    assign rd         = q.rd;
    assign wb_en      = q.wb_en;
    assign is_branch  = q.is_branch;
    assign is_jump    = q.is_jump;
    assign br_target  = q.br_target;
    assign mem_re     = q.mem_re;
    assign mem_we     = q.mem_we;
    assign illegal    = q.illegal;
endmodule

// File: tb/tb_id_ex_alu_ctrl_stage.sv
// Randomized bench for id_ex_alu_ctrl_stage: a reference decoder feeds a scoreboard queue
// that a negedge monitor drains whenever the stage presents an instruction.
module tb_id_ex_alu_ctrl_stage;
    import id_ex_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic [31:0] pc = '0;
    logic [31:0] rs1_data = '0;
    logic [31:0] rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    alu_sig_t    alu_ctrl;
    logic [31:0] alu_in1, alu_in2, store_data, br_target;
    logic [4:0]  rd;
    logic        wb_en, is_branch, is_jump, mem_re, mem_we, illegal;

    id_ex_alu_ctrl_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctrl(alu_ctrl),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .store_data(store_data), .rd(rd),
        .wb_en(wb_en), .is_branch(is_branch), .is_jump(is_jump), .br_target(br_target),
        .mem_re(mem_re), .mem_we(mem_we), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        alu_op_e     op;
        logic        s;
        logic [31:0] in1, in2, sd;
        logic [4:0]  rd;
        logic        wb, br, jmp;
        logic [31:0] tgt;
        logic        re, we, ill;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   mon_en = 1'b0;
    bit   exp_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decoder: immediates by arithmetic on the raw fields, ops from lookup tables.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] p,
                                        input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        alu_op_e     arith_map [8];
        alu_op_e     branch_map[8];
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] immi, imms, immb, immj, immu;
        bit          ok, wr, shift;
        arith_map  = '{add_, sl_, lt_, lt_, xor_, sr_, or_, and_};
        branch_map = '{eq_, ne_, nop_, nop_, lt_, ge_, lt_, ge_};
        f3   = w[14:12];
        f7   = w[31:25];
        immi = {20'b0, w[31:20]} - (w[31] ? 32'd4096 : 32'd0);
        imms = {20'b0, w[31:25], w[11:7]} - (w[31] ? 32'd4096 : 32'd0);
        immb = {19'b0, w[31], w[7], w[30:25], w[11:8], 1'b0} - (w[31] ? 32'd8192 : 32'd0);
        immj = {11'b0, w[31], w[19:12], w[20], w[30:21], 1'b0} - (w[31] ? 32'h200000 : 32'd0);
        immu = w & 32'hFFFF_F000;
        e  = '0;
        ok = 1'b1;
        wr = 1'b0;
        shift = (f3 == 3'd1) || (f3 == 3'd5);
        case (w[6:0])
            7'h33: begin
                ok   = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
                e.op = (f3 == 3'd0 && f7 == 7'h20) ? sub_ : arith_map[f3];
                e.s  = (f3 == 3'd2) || (f3 == 3'd5 && f7 == 7'h20);
                e.in1 = a; e.in2 = b; wr = 1'b1;
            end
            7'h13: begin
                ok   = !shift || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20);
                e.op = arith_map[f3];
                e.s  = (f3 == 3'd2) || (f3 == 3'd5 && f7 == 7'h20);
                e.in1 = a; e.in2 = shift ? {27'b0, w[24:20]} : immi; wr = 1'b1;
            end
            7'h37: begin e.op = imm_; e.in2 = immu; wr = 1'b1; end
            7'h17: begin e.op = add_; e.in1 = p; e.in2 = immu; wr = 1'b1; end
            7'h6F: begin e.op = add_; e.in1 = p; e.in2 = 32'd4; e.jmp = 1'b1; e.tgt = p + immj; wr = 1'b1; end
            7'h67: begin ok = (f3 == 3'd0); e.op = add_; e.in1 = p; e.in2 = 32'd4; e.jmp = 1'b1; wr = 1'b1; end
            7'h63: begin
                ok   = (f3 != 3'd2) && (f3 != 3'd3);
                e.op = branch_map[f3];
                e.s  = (f3 == 3'd4) || (f3 == 3'd5);
                e.in1 = a; e.in2 = b; e.br = 1'b1; e.tgt = p + immb;
            end
            7'h03: begin ok = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}; e.op = add_; e.in1 = a; e.in2 = a + immi - a; e.re = 1'b1; wr = 1'b1; end
            7'h23: begin ok = f3 inside {3'd0, 3'd1, 3'd2}; e.op = add_; e.in1 = a; e.in2 = imms; e.we = 1'b1; end
            default: ok = 1'b0;
        endcase
        e.sd = b;
        e.rd = wr ? w[11:7] : 5'd0;
        e.wb = wr && (w[11:7] != 5'd0);
        if (!ok) begin
            e     = '0;
            e.sd  = b;
            e.ill = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc[9];
        logic [31:0] w;
        int          k;
        opc = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
        w = $urandom;
        k = $urandom_range(0, 10);
        if (k < 9) w[6:0] = opc[k];
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    // One clock: account for what the stage was offered on this edge, then move off the edge.
    task automatic cycle();
        bit acc;
        @(posedge clk);
        if (mon_en) begin
            acc = in_valid && (!exp_valid || out_ready) && !flush;
            if (flush) exp_valid = 1'b0;
            else if (acc) begin
                sb_q.push_back(ref_decode(instr, pc, rs1_data, rs2_data));
                exp_valid = 1'b1;
            end else if (out_ready) exp_valid = 1'b0;
        end
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input logic [31:0] p, input logic [31:0] a,
                         input logic [31:0] b, input logic iv, input logic ordy, input logic fl);
        instr = w; pc = p; rs1_data = a; rs2_data = b;
        in_valid = iv; out_ready = ordy; flush = fl;
    endtask

    // Monitor: compare the presented instruction against the scoreboard head; retire it on
    // an EX transfer or a flush.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            check("out_valid", 32'(out_valid), 32'(exp_valid));
            check("in_ready", 32'(in_ready), 32'(!exp_valid || out_ready));
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb_q[0];
                    check("op", 32'(alu_ctrl.op), 32'(e.op));
                    check("is_signed", 32'(alu_ctrl.is_signed), 32'(e.s));
                    check("alu_in1", alu_in1, e.in1);
                    check("alu_in2", alu_in2, e.in2);
                    check("store_data", store_data, e.sd);
                    check("rd", 32'(rd), 32'(e.rd));
                    check("wb_en", 32'(wb_en), 32'(e.wb));
                    check("is_branch", 32'(is_branch), 32'(e.br));
                    check("is_jump", 32'(is_jump), 32'(e.jmp));
                    check("br_target", br_target, e.tgt);
                    check("mem_re", 32'(mem_re), 32'(e.re));
                    check("mem_we", 32'(mem_we), 32'(e.we));
                    check("illegal", 32'(illegal), 32'(e.ill));
                    if (out_ready || flush) void'(sb_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_op", 32'(alu_ctrl.op), 32'(nop_));
        check("rst_is_signed", 32'(alu_ctrl.is_signed), 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        check("rst_br_target", br_target, 32'd0);
        check("rst_wb_en", 32'(wb_en), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        mon_en = 1'b1;

        offer(32'h0020_81B3, 32'h0, 32'd5, 32'd7, 1'b1, 1'b1, 1'b0);
        cycle();
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_op", 32'(alu_ctrl.op), 32'(add_));
        check("add_in1", alu_in1, 32'd5);
        check("add_in2", alu_in2, 32'd7);
        check("add_rd", 32'(rd), 32'd3);
        check("add_wb_en", 32'(wb_en), 32'd1);

        offer(32'h4043_5293, 32'h4, 32'h8000_0000, 32'd0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("srai_op", 32'(alu_ctrl.op), 32'(sr_));
        check("srai_signed", 32'(alu_ctrl.is_signed), 32'd1);
        check("srai_in1", alu_in1, 32'h8000_0000);
        check("srai_in2", alu_in2, 32'd4);
        check("srai_rd", 32'(rd), 32'd5);

        offer(32'h0020_E863, 32'h100, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        cycle();
        check("bltu_op", 32'(alu_ctrl.op), 32'(lt_));
        check("bltu_signed", 32'(alu_ctrl.is_signed), 32'd0);
        check("bltu_is_branch", 32'(is_branch), 32'd1);
        check("bltu_target", br_target, 32'h110);
        check("bltu_wb_en", 32'(wb_en), 32'd0);

        offer(32'h0020_84B3, 32'h104, 32'd11, 32'd12, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_target", br_target, 32'h110);
            check("stall_op", 32'(alu_ctrl.op), 32'(lt_));
        end
        out_ready = 1'b1;
        cycle();
        check("nobubble_valid", 32'(out_valid), 32'd1);
        check("nobubble_rd", 32'(rd), 32'd9);
        check("nobubble_in1", alu_in1, 32'd11);

        offer(32'h4020_8533, 32'h108, 32'd20, 32'd3, 1'b1, 1'b0, 1'b1);
        cycle();
        check("flush_valid", 32'(out_valid), 32'd0);
        offer(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        cycle();
        check("flush_dropped", 32'(out_valid), 32'd0);

        offer(32'hFFFF_FFFF, 32'h10C, 32'd1, 32'd2, 1'b1, 1'b1, 1'b0);
        cycle();
        check("ill_valid", 32'(out_valid), 32'd1);
        check("ill_flag", 32'(illegal), 32'd1);
        check("ill_op", 32'(alu_ctrl.op), 32'(nop_));
        check("ill_wb_en", 32'(wb_en), 32'd0);

        for (int i = 0; i < 3000; i++) begin
            offer(rand_instr(), $urandom,
                  ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom, $urandom,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 15) == 0);
            cycle();
        end

        offer(32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle();
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        offer(32'h0020_81B3, 32'h200, 32'd1, 32'd1, 1'b1, 1'b1, 1'b0);
        cycle();
        out_ready = 1'b0;
        cycle();
        cycle();
        check("pre_reset_valid", 32'(out_valid), 32'd1);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("midstall_rst_valid", 32'(out_valid), 32'd0);
        check("midstall_rst_op", 32'(alu_ctrl.op), 32'(nop_));
        check("midstall_rst_in1", alu_in1, 32'd0);
        check("midstall_rst_rd", 32'(rd), 32'd0);
        sb_q.delete();
        exp_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
